// File: rtl/bus_demux4_if.sv
// bus_demux4_if
//   Bundles the initiator request/response channel and the shared four-target
//   request/response channel of the bus demultiplexer.
//   Initiator side : req_valid, req_ready, req_write, req_addr, req_wdata,
//                    resp_valid, resp_rdata, resp_err
//   Target side    : tgt_valid[3:0], tgt_ready[3:0], tgt_write, tgt_addr,
//                    tgt_wdata, tgt_resp_valid[3:0], tgt_rdata[4*DATA_SIZE-1:0]
//   modport slave  : the demultiplexer's view
//   modport master : the environment's view (initiator plus the four targets)
interface bus_demux4_if #(
    parameter int unsigned DATA_SIZE = 32,
    parameter int unsigned ADDR_SIZE = 32
);
    logic                   req_valid;
    logic                   req_ready;
    logic                   req_write;
    logic [ADDR_SIZE-1:0]   req_addr;
    logic [DATA_SIZE-1:0]   req_wdata;
    logic                   resp_valid;
    logic [DATA_SIZE-1:0]   resp_rdata;
    logic                   resp_err;
    logic [3:0]             tgt_valid;
    logic [3:0]             tgt_ready;
    logic                   tgt_write;
    logic [ADDR_SIZE-1:0]   tgt_addr;
    logic [DATA_SIZE-1:0]   tgt_wdata;
    logic [3:0]             tgt_resp_valid;
    logic [4*DATA_SIZE-1:0] tgt_rdata;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        input  tgt_ready, tgt_resp_valid, tgt_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output tgt_valid, tgt_write, tgt_addr, tgt_wdata
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        output tgt_ready, tgt_resp_valid, tgt_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  tgt_valid, tgt_write, tgt_addr, tgt_wdata
    );
endinterface

// File: rtl/bus_demux4.sv
// bus_demux4
//   Single-initiator to four-target bus demultiplexer. One load/store at a
//   time is steered to target addr[ADDR_SIZE-1:ADDR_SIZE-2] (0 data RAM,
//   1 I/O, 2 timer, 3 spare) and the target's response is returned as a
//   one-cycle resp_valid pulse. Absent targets (TGT_EN) and hung targets
//   (TIMEOUT cycles, 0 = never) produce an error response.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset; aborts any transaction in flight
//     bus    bus_demux4_if.slave (initiator and target channels)
//   All outputs are registered.
module bus_demux4 #(
    parameter int unsigned DATA_SIZE = 32,
    parameter int unsigned ADDR_SIZE = 32,
    parameter logic [3:0]  TGT_EN    = 4'b1111,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    bus_demux4_if.slave bus
);
    localparam int unsigned   TW   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TLIM = TW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        RESP
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           sel_q, sel_d;
    logic [TW-1:0]        timer_q, timer_d, timer_inc;
    logic                 err_q, err_d;
    logic [DATA_SIZE-1:0] rdata_q, rdata_d;
    logic                 accept;
    logic                 ready_sel;
    logic                 resp_sel;
    logic                 timeout_hit;
    logic [DATA_SIZE-1:0] rdata_sel;

    always_comb begin
        ready_sel = bus.tgt_ready[sel_q];
        resp_sel  = bus.tgt_resp_valid[sel_q];
        rdata_sel = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (sel_q == 2'(i)) begin
                rdata_sel = bus.tgt_rdata[i*DATA_SIZE +: DATA_SIZE];
            end
        end
        timeout_hit = (TIMEOUT != 0) && (timer_q == TLIM);
        // Saturate so a ready taken at the limit still leaves WAIT guarded.
        timer_inc   = (timer_q == TLIM) ? timer_q : timer_q + TW'(1);

        accept  = 1'b0;
        state_d = state_q;
        sel_d   = sel_q;
        timer_d = timer_q;
        err_d   = err_q;
        rdata_d = rdata_q;

        unique case (state_q)
            IDLE: begin
                err_d = 1'b0;
                if (bus.req_valid && bus.req_ready) begin
                    accept  = 1'b1;
                    sel_d   = bus.req_addr[ADDR_SIZE-1 -: 2];
                    timer_d = '0;
                    rdata_d = '0;
                    if (TGT_EN[sel_d]) begin
                        state_d = REQ;
                    end else begin
                        state_d = RESP;
                        err_d   = 1'b1;
                    end
                end
            end
            REQ: begin
                timer_d = timer_inc;
                if (ready_sel) begin
                    if (resp_sel) begin
                        rdata_d = bus.tgt_write ? '0 : rdata_sel;
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                    end
                end else if (timeout_hit) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            WAIT: begin
                timer_d = timer_inc;
                if (resp_sel) begin
                    rdata_d = bus.tgt_write ? '0 : rdata_sel;
                    state_d = RESP;
                end else if (timeout_hit) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state, so tgt_valid and req_ready
    // line up with the state they describe; the response pulse is issued on
    // the edge that leaves RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            sel_q          <= '0;
            timer_q        <= '0;
            err_q          <= 1'b0;
            rdata_q        <= '0;
            bus.req_ready  <= 1'b0;
            bus.resp_valid <= 1'b0;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= '0;
            bus.tgt_valid  <= '0;
            bus.tgt_write  <= 1'b0;
            bus.tgt_addr   <= '0;
            bus.tgt_wdata  <= '0;
        end else begin
            state_q        <= state_d;
            sel_q          <= sel_d;
            timer_q        <= timer_d;
            err_q          <= err_d;
            rdata_q        <= rdata_d;
            bus.req_ready  <= (state_d == IDLE);
            bus.resp_valid <= (state_q == RESP);
            bus.resp_err   <= (state_q == RESP) && err_q;
            bus.resp_rdata <= (state_q == RESP) ? rdata_q : '0;
            bus.tgt_valid  <= (state_d == REQ) ? (4'b0001 << sel_d) : 4'b0000;
            if (accept) begin
                bus.tgt_write <= bus.req_write;
                bus.tgt_addr  <= bus.req_addr;
                bus.tgt_wdata <= bus.req_wdata;
            end
        end
    end
endmodule
